// File: rtl/proj_mem_paged.sv
// Paged projection store: one RAM page per BX, per-page entry count and overflow.
// Optional PROJ_MEM_DROP_CNT_EN adds a saturating dropped-write counter output.
module proj_mem_paged #(
    parameter int DATA_W = 56,
    parameter int ADDR_W = 6,
    parameter int PAGE_W = 3,
    parameter int TMUX   = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               start,
    output logic [1:0]               done,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     enable,
    input  logic [PAGE_W+ADDR_W-1:0] read_add,
    output logic [DATA_W-1:0]        data_out,
    output logic [ADDR_W:0]          rd_nent,
    output logic                     rd_ovf
`ifdef PROJ_MEM_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int NPAGE = 1 << PAGE_W;
    localparam int DEPTH = 1 << (PAGE_W + ADDR_W);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(1) << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PAGE_W-1:0]            wr_page_q, wr_page_d;
    logic [NPAGE-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NPAGE-1:0]             ovf_q, ovf_d;
    logic                         we1_q, we1_d;
    logic [DATA_W-1:0]            d1_q;

    logic [PAGE_W+ADDR_W-1:0]     raddr_q;
    logic [DATA_W-1:0]            ram_q;
    logic [DATA_W-1:0]            dout_q;
    logic [CNT_W-1:0]             nent1_q, nent2_q, nent3_q;
    logic                         ovf1_q, ovf2_q, ovf3_q;

    logic [TMUX-1:0][1:0]         done_q;

    logic                         sync_clr;
    logic                         bx_start;
    logic                         wr_full;
    logic                         wr_go;
    logic                         wr_drop;
    logic [PAGE_W-1:0]            next_page;
    logic [PAGE_W-1:0]            rd_page;
    logic [PAGE_W+ADDR_W-1:0]     wr_addr;

    assign sync_clr  = start[1];
    assign bx_start  = start[0];
    assign next_page = wr_page_q + PAGE_W'(1);
    assign rd_page   = read_add[PAGE_W+ADDR_W-1 -: PAGE_W];
    assign wr_full   = (cnt_q[wr_page_q] == FULL);
    assign wr_go     = we1_q && !wr_full && !sync_clr;
    assign wr_drop   = we1_q && wr_full && !sync_clr;
    assign wr_addr   = {wr_page_q, cnt_q[wr_page_q][ADDR_W-1:0]};

    // Page pointer and per-page count/overflow next state; a page switch clears the new page.
    always_comb begin
        wr_page_d = wr_page_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        we1_d     = enable;
        if (sync_clr) begin
            wr_page_d = '1;
            cnt_d     = '0;
            ovf_d     = '0;
            we1_d     = 1'b0;
        end else begin
            if (wr_go) begin
                cnt_d[wr_page_q] = cnt_q[wr_page_q] + CNT_W'(1);
            end
            if (wr_drop) begin
                ovf_d[wr_page_q] = 1'b1;
            end
            if (bx_start) begin
                wr_page_d        = next_page;
                cnt_d[next_page] = '0;
                ovf_d[next_page] = 1'b0;
            end
        end
    end

    // Write-side state registers, including the one-stage input register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_page_q <= '1;
            cnt_q     <= '0;
            ovf_q     <= '0;
            we1_q     <= 1'b0;
            d1_q      <= '0;
        end else begin
            wr_page_q <= wr_page_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            we1_q     <= we1_d;
            d1_q      <= data_in;
        end
    end

    // Dual-port RAM, read-first, with registered read data; contents never cleared.
    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem_q[wr_addr] <= d1_q;
        end
        ram_q <= mem_q[raddr_q];
    end

    // Read pipeline: address, RAM out, output stage; count/ovf sampled with the address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raddr_q <= '0;
            dout_q  <= '0;
            nent1_q <= '0;
            nent2_q <= '0;
            nent3_q <= '0;
            ovf1_q  <= 1'b0;
            ovf2_q  <= 1'b0;
            ovf3_q  <= 1'b0;
        end else if (sync_clr) begin
            raddr_q <= '0;
            dout_q  <= '0;
            nent1_q <= '0;
            nent2_q <= '0;
            nent3_q <= '0;
            ovf1_q  <= 1'b0;
            ovf2_q  <= 1'b0;
            ovf3_q  <= 1'b0;
        end else begin
            raddr_q <= read_add;
            dout_q  <= ram_q;
            nent1_q <= cnt_q[rd_page];
            nent2_q <= nent1_q;
            nent3_q <= nent2_q;
            ovf1_q  <= ovf_q[rd_page];
            ovf2_q  <= ovf1_q;
            ovf3_q  <= ovf2_q;
        end
    end

    // Start delay line; only the async reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= '0;
        end else begin
            done_q <= {done_q[TMUX-2:0], start};
        end
    end

    assign done     = done_q[TMUX-1];
    assign data_out = dout_q;
    assign rd_nent  = nent3_q;
    assign rd_ovf   = ovf3_q;

`ifdef PROJ_MEM_DROP_CNT_EN
    logic [15:0] drop_q;

    // Saturating count of writes dropped on full pages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else if (sync_clr) begin
            drop_q <= '0;
        end else if (wr_drop && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: doc/proj_mem_paged.md
Name: proj_mem_paged

Overview:
Parametrised successor to the single-layer all-projection store. Buffers projection words for a series of bunch crossings (BX) in a paged dual-port RAM, one page per BX, selected by a rolling BX page counter. Unlike the previous store, it tracks a per-page entry count and drops writes when a page is full, flagging overflow. It exports count and overflow to the downstream matching stage. One instance sits between each projection router output and its match engine.

Parameters:
DATA_W, 56, projection word width.
ADDR_W, 6, log2 of entries per page.
PAGE_W, 3, log2 of page count (BX pages kept in flight).
TMUX, 6, start-to-done latency in clocks.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  2  [0] BX start pulse; [1] synchronous pipeline reset.
done  out  2  start delayed by TMUX clocks.
data_in  in  DATA_W  projection word.
enable  in  1  data_in valid this cycle.
read_add  in  PAGE_W+ADDR_W  {page, entry} read address.
data_out  out  DATA_W  read data.
rd_nent  out  ADDR_W+1  entry count of page read_add[top PAGE_W bits].
rd_ovf  out  1  overflow flag of that page.

Behaviour:
- Async reset: wr_page = all ones, so the first start[0] selects page 0. All page counts = 0, all ovf = 0, done = 0, data_out = 0, rd_nent = 0, rd_ovf = 0, internal write-enable = 0. RAM contents are undefined and not cleared.
- start[1] (sync): same clearing as reset at the next edge; RAM contents are untouched. It has priority over start[0] and enable in the same cycle.
- start[0]: at the edge, wr_page <= wr_page+1 modulo 2^PAGE_W. The new page's count and ovf clear at that same edge. Pages wrap and overwrite the oldest BX; no protection against still-unread pages.
- Write pipeline: data_in/enable registered one stage (stage W1). The register is written at {wr_page, count[wr_page]} on the following edge.
- An enable sampled in the same cycle as start[0] belongs to the new page at entry 0.
- Count is ADDR_W+1 bits and saturates at 2^ADDR_W (full).
- A write while full is dropped: RAM not written, ovf[wr_page] set (sticky until that page is reused or reset).
- Write address is taken from the count, not a free-running pointer, so no wrap within a page.
- Read: data_out valid 3 clocks after read_add (RAM address reg, RAM output reg, output reg). rd_nent/rd_ovf are pipelined to the same 3-clock alignment.
- Read and write to the same address in the same cycle: read returns old contents (read-first).
- Reading the page currently being written: rd_nent reflects the count at the time of read_add sampling.
- done: shift register of depth TMUX on start, cleared by reset only (not start[1]).

Optional Feature:
Macro PROJ_MEM_DROP_CNT_EN.
- Defined: adds output port drop_cnt [15:0], a saturating count of dropped writes across all pages (stops at 16'hFFFF). Cleared by reset and start[1]; not cleared by start[0].
- Undefined: port and counter absent; drops visible only via rd_ovf.

Test Plan:
- Reset, start[0] pulse, 5 enabled words 0x1..0x5 -> page 0 entries 0..4 hold 0x1..0x5; read_add {0,2} gives data_out 0x3 three clocks later; rd_nent = 5, rd_ovf = 0.
- 66 enabled writes into one page (ADDR_W=6) -> rd_nent = 64, rd_ovf = 1, entry 63 holds the 64th word; drop_cnt = 2 with PROJ_MEM_DROP_CNT_EN.
- 9 start[0] pulses with 1 write each (PAGE_W=3) -> 9th BX overwrites page 0; rd_nent(page 0) = 1 with the new data; ovf of page 0 cleared.
- start[0] and enable high in the same cycle with data 0xAA -> 0xAA lands at {new page, 0}; the previous page's count is unchanged.
- start[1] asserted mid-burst -> counts/ovf/drop_cnt = 0 next cycle; the next start[0] selects page 0; done pipeline unaffected.
- Async reset asserted between clock edges -> all outputs 0 immediately; done = 0 until TMUX clocks after the next start.
